// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter front-end: op encodings,
// datapath width and the arbiter FSM state type.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;
   localparam int         ALU_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu.sv
// 16-bit ripple ALU: add, sub (a + ~b + 1), and, or.
// cout is the ripple carry of the add/sub chain; for sub, 1 means no borrow.
module alu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [1:0]       op,
   output logic [ALU_W-1:0] o,
   output logic             cout
);

   logic [ALU_W-1:0] bx;
   logic [ALU_W-1:0] sum;
   logic             c;

   // ripple carry chain, then select the result by op
   always_comb begin
      bx   = (op == OP_SUB) ? ~b : b;
      c    = (op == OP_SUB);
      sum  = '0;
      for (int i = 0; i < ALU_W; i++) begin
         sum[i] = a[i] ^ bx[i] ^ c;
         c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
      end
      cout = c;
      case (op)
         OP_AND:  o = a & b;
         OP_OR:   o = a | b;
         default: o = sum;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            any
);

   int idx;

   // walk offsets from farthest to nearest so the nearest hit wins
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) begin
            gnt_id = IDW'(idx);
            any    = 1'b1;
         end
      end
      if (any) gnt[gnt_id] = 1'b1;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one ALU among NREQ requesters.
// Optional macro ALU_ARB_ZFLAG_EN adds a registered rsp_zero output.
//
// state | meaning
// IDLE  | arbitrating; granted requester sees req_ready this cycle
// EXEC  | ALU pass on latched operands; result captured at end of cycle
// RESP  | result held on rsp_*; leaves when rsp_ready is seen
module alu_arbiter
   import alu_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [ALU_W*NREQ-1:0] req_a,
   input  logic [ALU_W*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [ALU_W-1:0]      rsp_data,
   output logic                  rsp_cout,
`ifdef ALU_ARB_ZFLAG_EN
   output logic                  rsp_zero,
`endif
   output logic                  busy
);

   state_t           state;
   logic [1:0]       op_q;
   logic [ALU_W-1:0] a_q;
   logic [ALU_W-1:0] b_q;
   logic [ALU_W-1:0] res_q;
   logic             cout_q;
   logic [IDW-1:0]   id_q;
   logic [IDW-1:0]   rr_ptr;
`ifdef ALU_ARB_ZFLAG_EN
   logic             zero_q;
`endif

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_id;
   logic             any;
   logic [1:0]       sel_op;
   logic [ALU_W-1:0] sel_a;
   logic [ALU_W-1:0] sel_b;
   logic [IDW-1:0]   next_ptr;
   logic [ALU_W-1:0] alu_o;
   logic             alu_cout;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   // the shared ALU only ever sees the latched operands
   alu u_alu (
      .a    (a_q),
      .b    (b_q),
      .op   (op_q),
      .o    (alu_o),
      .cout (alu_cout)
   );

   // mux the granted requester's op and operands
   always_comb begin
      sel_op   = '0;
      sel_a    = '0;
      sel_b    = '0;
      next_ptr = IDW'((int'(gnt_id) + 1) % NREQ);
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_op = req_op[2*i +: 2];
            sel_a  = req_a[ALU_W*i +: ALU_W];
            sel_b  = req_b[ALU_W*i +: ALU_W];
         end
      end
   end

   // accept is same-cycle, so req_ready comes straight from the arbiter
   always_comb begin
      req_ready = (state == IDLE && !reset) ? gnt : '0;
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign rsp_id    = id_q;
   assign rsp_data  = res_q;
   assign rsp_cout  = cout_q;
`ifdef ALU_ARB_ZFLAG_EN
   assign rsp_zero  = zero_q;
`endif

   // FSM with operand/result registers and the round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         cout_q <= 1'b0;
         id_q   <= '0;
         rr_ptr <= '0;
`ifdef ALU_ARB_ZFLAG_EN
         zero_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  op_q   <= sel_op;
                  a_q    <= sel_a;
                  b_q    <= sel_b;
                  id_q   <= gnt_id;
                  rr_ptr <= next_ptr;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               res_q  <= alu_o;
               cout_q <= alu_cout & ~op_q[1];
`ifdef ALU_ARB_ZFLAG_EN
               zero_q <= (alu_o == '0);
`endif
               state  <= RESP;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NREQ=2): directed vector table,
// hand-written corner sequences and a randomized run against a
// transaction-level reference model.
module tb_alu_arbiter;

   localparam int NREQ = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [0:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        rsp_cout;
   logic        busy;
`ifdef ALU_ARB_ZFLAG_EN
   logic        rsp_zero;
`endif

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_cout  (rsp_cout),
`ifdef ALU_ARB_ZFLAG_EN
      .rsp_zero  (rsp_zero),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      logic        c;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // reference arithmetic from the op definitions: {cout, result}
   function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      case (op)
         2'b00:   s = {1'b0, a} + {1'b0, b};
         2'b01:   s = {(a >= b), 16'(a - b)};
         2'b10:   s = {1'b0, a & b};
         default: s = {1'b0, a | b};
      endcase
      return s;
   endfunction

   task automatic set_req(input int id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      req_op[2*id +: 2]  = op;
      req_a[16*id +: 16] = a;
      req_b[16*id +: 16] = b;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // one op from a single requester with rsp_ready held high
   task automatic do_op(input vec_t v, input string name);
      int         n;
      logic [1:0] oh;
      oh = 2'b01 << v.id;
      @(posedge clk); #1;
      set_req(v.id, v.op, v.a, v.b);
      req_valid = oh;
      rsp_ready = 1'b1;
      @(negedge clk);
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_ready"}, 32'(req_ready), 32'(oh));
      if (req_ready == 2'b00) begin
         req_valid = '0;
         return;
      end
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      chk({name, "_exec"}, {30'd0, rsp_valid, busy}, 32'b01);
      @(negedge clk);
      chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, "_id"}, 32'(rsp_id), 32'(v.id));
      chk({name, "_data"}, 32'(rsp_data), 32'(v.d));
      chk({name, "_cout"}, 32'(rsp_cout), 32'(v.c));
`ifdef ALU_ARB_ZFLAG_EN
      chk({name, "_zero"}, 32'(rsp_zero), 32'(v.d == 16'h0000));
`endif
      @(negedge clk);
      chk({name, "_done"}, {30'd0, rsp_valid, busy}, 32'b00);
   endtask

   vec_t vecs[7];

   int          n;
   int          exp_id;
   int          m_phase;
   int          m_ptr;
   int          m_id;
   int          gid;
   logic [16:0] m_res;
   logic [1:0]  exp_rdy;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;

      vecs[0] = '{0, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
      vecs[1] = '{1, 2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
      vecs[2] = '{1, 2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b1};
      vecs[3] = '{0, 2'b10, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
      vecs[4] = '{1, 2'b11, 16'h1200, 16'h0034, 16'h1234, 1'b0};
      vecs[5] = '{0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
      vecs[6] = '{0, 2'b01, 16'h0004, 16'h0004, 16'h0000, 1'b1};

      // reset held 3 cycles, then idle with no requests
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
`ifdef ALU_ARB_ZFLAG_EN
         chk("idle_outputs", {8'd0, req_ready, rsp_valid, rsp_id, rsp_data, rsp_cout, busy, rsp_zero},
             32'd0);
`else
         chk("idle_outputs", {9'd0, req_ready, rsp_valid, rsp_id, rsp_data, rsp_cout, busy}, 32'd0);
`endif
      end

      // directed vector table
      for (int i = 0; i < 7; i++) do_op(vecs[i], $sformatf("vec%0d", i));

      // both requesters held valid: grants alternate starting at 0
      do_reset();
      set_req(0, 2'b00, 16'h0001, 16'h0001);
      set_req(1, 2'b00, 16'h0002, 16'h0002);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      exp_id    = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n = 0;
         while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(2'b01 << exp_id));
         @(posedge clk); #1;
         chk($sformatf("rr_ptr%0d", k), 32'(dut.rr_ptr), 32'((exp_id + 1) % NREQ));
         exp_id = exp_id ^ 1;
      end
      req_valid = '0;
      repeat (4) @(posedge clk);

      // backpressure: req1 and-op held for 5 cycles, req0 waiting behind it
      #1;
      set_req(1, 2'b10, 16'hF0F0, 16'h0FF0);
      set_req(0, 2'b00, 16'h0000, 16'h0000);
      req_valid = 2'b10;
      rsp_ready = 1'b0;
      @(negedge clk);
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_grant", 32'(req_ready), 32'b10);
      @(posedge clk); #1 req_valid = 2'b11;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", k), {req_ready, rsp_valid, rsp_id, rsp_cout, rsp_data},
             {2'b00, 1'b1, 1'b1, 1'b0, 16'h00F0});
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_handshake", {29'd0, req_ready, rsp_valid}, {29'd0, 2'b00, 1'b1});
      @(negedge clk);
      chk("bp_after", {29'd0, req_ready, rsp_valid}, {29'd0, 2'b01, 1'b0});
      req_valid = '0;

      // reset during EXEC of an or op discards the result
      @(posedge clk); #1;
      set_req(0, 2'b11, 16'h1234, 16'h00F0);
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      @(negedge clk);
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_exec_grant", 32'(req_ready), 32'b01);
      @(posedge clk); #1;
      req_valid = '0;
      reset     = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rst_exec_quiet", {30'd0, rsp_valid, busy}, 32'd0);
      end
      do_op('{0, 2'b11, 16'h1234, 16'h00F0, 16'h12F4, 1'b0}, "rst_exec_next");

      // randomized run against the transaction model
      do_reset();
      m_phase = 0;
      m_ptr   = 0;
      m_id    = 0;
      m_res   = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         req_valid = 2'($urandom_range(0, 3));
         for (int r = 0; r < NREQ; r++) begin
            set_req(r, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                    ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         gid     = -1;
         exp_rdy = '0;
         if (m_phase == 0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
               if (req_valid[(m_ptr + k) % NREQ]) gid = (m_ptr + k) % NREQ;
            end
            if (gid >= 0) exp_rdy = 2'b01 << gid;
         end
         chk("rand_ready", 32'(req_ready), 32'(exp_rdy));
         chk("rand_state", {30'd0, rsp_valid, busy}, {30'd0, (m_phase == 2), (m_phase != 0)});
         if (m_phase == 2) begin
            chk("rand_rsp", {14'd0, rsp_id, rsp_cout, rsp_data}, {14'd0, 1'(m_id), m_res});
`ifdef ALU_ARB_ZFLAG_EN
            chk("rand_zero", 32'(rsp_zero), 32'(m_res[15:0] == 16'h0000));
`endif
         end
         if (m_phase == 0) begin
            if (gid >= 0) begin
               m_res   = ref_alu(req_op[2*gid +: 2], req_a[16*gid +: 16], req_b[16*gid +: 16]);
               m_id    = gid;
               m_ptr   = (gid + 1) % NREQ;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (rsp_ready) begin
            m_phase = 0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
